cmos_and2_switch_model: RTL and testbench



---
 rtl/cmos_and2_switch_model_if.sv | 28 ++
 rtl/cmos_and2_switch_model.sv | 185 ++++++++++++++++++
 tb/tb_cmos_and2_switch_model.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_and2_switch_model_if.sv
// Signal bundle for the CMOS AND2 switch-level model: two logic inputs,
// the resolved output value with its X flag, and the w4 node status flags.
interface cmos_and2_switch_model_if;
    logic in1;
    logic in2;
    logic out1;
    logic out1_x;
    logic w4_conflict;
    logic w4_float;

    modport master (
        output in1,
        output in2,
        input  out1,
        input  out1_x,
        input  w4_conflict,
        input  w4_float
    );

    modport slave (
        input  in1,
        input  in2,
        output out1,
        output out1_x,
        output w4_conflict,
        output w4_float
    );
endinterface

// File: rtl/cmos_and2_switch_model.sv
// Cycle-based switch-level model of a two-input CMOS AND gate: a 4-transistor
// NAND stage driving internal node w4, followed by a 2-transistor inverter.
// Every device is a delay line on its gate signal; nodes resolve each cycle to
// 0, 1 or X, or keep their stored charge when nothing drives them.
// Node encoding: 2'b00 = 0, 2'b01 = 1, 2'b10 = X.

// Gate-signal delay line for one transistor; the last stage is the effective gate.
module cmos_switch_delay_line #(
    parameter int         D       = 1,
    parameter logic [1:0] RST_VAL = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_gate,
    output logic [1:0] o_gate
);
    logic [1:0] r_stage [D];

    // Shift the gate value one stage per cycle; reset reloads every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_gate;
            for (int i = 1; i < D; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_gate = r_stage[D-1];
endmodule

module cmos_and2_switch_model #(
    parameter int D_P1 = 3,
    parameter int D_N2 = 3,
    parameter int D_N3 = 1,
    parameter int D_P4 = 3,
    parameter int D_P5 = 2,
    parameter int D_N6 = 2
) (
    input logic                    clk,
    input logic                    rst,
    cmos_and2_switch_model_if.slave bus
);
    localparam logic [1:0] L0 = 2'b00;
    localparam logic [1:0] L1 = 2'b01;
    localparam logic [1:0] LX = 2'b10;

    // Conduction codes: definitely off, definitely on, maybe on.
    localparam logic [1:0] C_OFF   = 2'b00;
    localparam logic [1:0] C_ON    = 2'b01;
    localparam logic [1:0] C_MAYBE = 2'b10;

    if (D_P1 < 1 || D_P1 > 16 || D_N2 < 1 || D_N2 > 16 ||
        D_N3 < 1 || D_N3 > 16 || D_P4 < 1 || D_P4 > 16 ||
        D_P5 < 1 || D_P5 > 16 || D_N6 < 1 || D_N6 > 16) begin : g_bad_delay
        $error("cmos_and2_switch_model: every device delay must be in 1..16");
    end

    function automatic logic [1:0] nmos_cond(input logic [1:0] g);
        logic [1:0] c;
        case (g)
            L1:      c = C_ON;
            L0:      c = C_OFF;
            default: c = C_MAYBE;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] pmos_cond(input logic [1:0] g);
        logic [1:0] c;
        case (g)
            L0:      c = C_ON;
            L1:      c = C_OFF;
            default: c = C_MAYBE;
        endcase
        return c;
    endfunction

    // Two devices in parallel: any definite path wins, else any maybe path.
    function automatic logic [1:0] par_cond(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] c;
        if (a == C_ON || b == C_ON) begin
            c = C_ON;
        end else if (a == C_MAYBE || b == C_MAYBE) begin
            c = C_MAYBE;
        end else begin
            c = C_OFF;
        end
        return c;
    endfunction

    // Two devices in series: one definite break kills the path.
    function automatic logic [1:0] ser_cond(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] c;
        if (a == C_OFF || b == C_OFF) begin
            c = C_OFF;
        end else if (a == C_ON && b == C_ON) begin
            c = C_ON;
        end else begin
            c = C_MAYBE;
        end
        return c;
    endfunction

    function automatic logic [1:0] resolve_val(input logic [1:0] up, input logic [1:0] dn,
                                               input logic [1:0] stored);
        logic [1:0] v;
        if (up == C_OFF && dn == C_OFF) begin
            v = stored;
        end else if (up == C_ON && dn == C_OFF) begin
            v = L1;
        end else if (dn == C_ON && up == C_OFF) begin
            v = L0;
        end else begin
            v = LX;
        end
        return v;
    endfunction

    // Contention: a definite driver facing any driver on the opposite rail.
    function automatic logic is_conflict(input logic [1:0] up, input logic [1:0] dn);
        return (up == C_ON && dn != C_OFF) || (dn == C_ON && up != C_OFF);
    endfunction

    function automatic logic is_float(input logic [1:0] up, input logic [1:0] dn);
        return (up == C_OFF) && (dn == C_OFF);
    endfunction

    logic [1:0] w_g_p1, w_g_n2, w_g_n3, w_g_p4, w_g_p5, w_g_n6;
    logic [1:0] w_w4_up, w_w4_dn, w_out_up, w_out_dn;
    logic [1:0] w_w4_val, w_out_val;
    logic [1:0] r_w4_store, r_out_store;
    logic       r_out1, r_out1_x, r_w4_conflict, r_w4_float;

    cmos_switch_delay_line #(.D(D_P1), .RST_VAL(L0)) u_pmos_1 (
        .clk(clk), .rst(rst), .i_gate({1'b0, bus.in1}), .o_gate(w_g_p1));
    cmos_switch_delay_line #(.D(D_N2), .RST_VAL(L0)) u_nmos_2 (
        .clk(clk), .rst(rst), .i_gate({1'b0, bus.in1}), .o_gate(w_g_n2));
    cmos_switch_delay_line #(.D(D_N3), .RST_VAL(L0)) u_nmos_3 (
        .clk(clk), .rst(rst), .i_gate({1'b0, bus.in2}), .o_gate(w_g_n3));
    cmos_switch_delay_line #(.D(D_P4), .RST_VAL(L0)) u_pmos_4 (
        .clk(clk), .rst(rst), .i_gate({1'b0, bus.in2}), .o_gate(w_g_p4));
    cmos_switch_delay_line #(.D(D_P5), .RST_VAL(L1)) u_pmos_5 (
        .clk(clk), .rst(rst), .i_gate(w_w4_val), .o_gate(w_g_p5));
    cmos_switch_delay_line #(.D(D_N6), .RST_VAL(L1)) u_nmos_6 (
        .clk(clk), .rst(rst), .i_gate(w_w4_val), .o_gate(w_g_n6));

    // Resolve the NAND node w4 and the output node from the effective gates.
    always_comb begin
        w_w4_up   = par_cond(pmos_cond(w_g_p1), pmos_cond(w_g_p4));
        w_w4_dn   = ser_cond(nmos_cond(w_g_n2), nmos_cond(w_g_n3));
        w_w4_val  = resolve_val(w_w4_up, w_w4_dn, r_w4_store);
        w_out_up  = pmos_cond(w_g_p5);
        w_out_dn  = nmos_cond(w_g_n6);
        w_out_val = resolve_val(w_out_up, w_out_dn, r_out_store);
    end

    // Store node charge and register the observation outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w4_store    <= L1;
            r_out_store   <= L0;
            r_out1        <= 1'b0;
            r_out1_x      <= 1'b0;
            r_w4_conflict <= 1'b0;
            r_w4_float    <= 1'b0;
        end else begin
            r_w4_store    <= w_w4_val;
            r_out_store   <= w_out_val;
            r_out1        <= (w_out_val == L1);
            r_out1_x      <= (w_out_val == LX);
            r_w4_conflict <= is_conflict(w_w4_up, w_w4_dn);
            r_w4_float    <= is_float(w_w4_up, w_w4_dn);
        end
    end

    assign bus.out1        = r_out1;
    assign bus.out1_x      = r_out1_x;
    assign bus.w4_conflict = r_w4_conflict;
    assign bus.w4_float    = r_w4_float;
endmodule

// File: tb/tb_cmos_and2_switch_model.sv
// Bench for the CMOS AND2 switch-level model: directed scenarios with
// hand-derived expectations plus toggled and random stimulus against a
// history-indexed reference model using drive strengths (0 none, 1 maybe, 2 strong).
module tb_cmos_and2_switch_model;
    localparam int D_P1 = 3;
    localparam int D_N2 = 3;
    localparam int D_N3 = 1;
    localparam int D_P4 = 3;
    localparam int D_P5 = 2;
    localparam int D_N6 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cmos_and2_switch_model_if u_if ();

    cmos_and2_switch_model #(
        .D_P1(D_P1), .D_N2(D_N2), .D_N3(D_N3),
        .D_P4(D_P4), .D_P5(D_P5), .D_N6(D_N6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    always #5 clk = ~clk;

    // Reference model: values indexed by cycles since the last reset edge.
    // Node values: 0, 1, 2 (= X).
    int hist1 [0:1023];
    int hist2 [0:1023];
    int w4r   [0:1023];
    int w4c   [0:1023];
    int w4f   [0:1023];
    int outr  [0:1023];
    int mn = 0;
    bit cur1 = 1'b0, cur2 = 1'b0;
    bit e_out1, e_x, e_conf, e_float;

    function automatic int pstr(int g);
        return (g == 0) ? 2 : (g == 1) ? 0 : 1;
    endfunction

    function automatic int nstr(int g);
        return (g == 1) ? 2 : (g == 0) ? 0 : 1;
    endfunction

    function automatic int gate_a(int n, int d);
        int idx = n - d + 1;
        return (idx < 1) ? 0 : hist1[idx];
    endfunction

    function automatic int gate_b(int n, int d);
        int idx = n - d + 1;
        return (idx < 1) ? 0 : hist2[idx];
    endfunction

    function automatic int gate_w(int n, int d);
        int idx = n - d + 1;
        return (idx < 1) ? 1 : w4r[idx-1];
    endfunction

    task automatic resolve(input int up, input int dn, input int stored,
                           output int v, output int c, output int f);
        c = 0; f = 0;
        if (up == 0 && dn == 0) begin
            v = stored; f = 1;
        end else if (dn == 0 && up == 2) begin
            v = 1;
        end else if (up == 0 && dn == 2) begin
            v = 0;
        end else begin
            v = 2;
            c = ((up > dn ? up : dn) == 2) ? 1 : 0;
        end
    endtask

    task automatic model_eval(input int n);
        int up, dn, v, c, f, a, b;
        a  = pstr(gate_a(n, D_P1));
        b  = pstr(gate_b(n, D_P4));
        up = (a > b) ? a : b;
        a  = nstr(gate_a(n, D_N2));
        b  = nstr(gate_b(n, D_N3));
        dn = (a < b) ? a : b;
        resolve(up, dn, (n == 0) ? 1 : w4r[n-1], v, c, f);
        w4r[n] = v; w4c[n] = c; w4f[n] = f;
        resolve(pstr(gate_w(n, D_P5)), nstr(gate_w(n, D_N6)),
                (n == 0) ? 0 : outr[n-1], v, c, f);
        outr[n] = v;
    endtask

    task automatic set_in(input bit a, input bit b);
        u_if.in1 = a; u_if.in2 = b;
        cur1 = a; cur2 = b;
    endtask

    // Advance one clock edge and move the reference model along with it.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst) begin
            mn = 0;
            e_out1 = 1'b0; e_x = 1'b0; e_conf = 1'b0; e_float = 1'b0;
            model_eval(0);
        end else begin
            e_out1  = (outr[mn] == 1);
            e_x     = (outr[mn] == 2);
            e_conf  = (w4c[mn] != 0);
            e_float = (w4f[mn] != 0);
            if (mn < 1023) mn++;
            hist1[mn] = cur1 ? 1 : 0;
            hist2[mn] = cur2 ? 1 : 0;
            model_eval(mn);
        end
    endtask

    task automatic start_from_reset(input bit a, input bit b, input int settle);
        rst = 1'b1; set_in(1'b0, 1'b0); cyc();
        rst = 1'b0; set_in(a, b);
        repeat (settle) cyc();
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1; set_in(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            obs = {u_if.out1, u_if.out1_x, u_if.w4_conflict, u_if.w4_float};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=0000", i, obs);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_rise();
        logic [3:0] obs, exp;
        start_from_reset(1'b0, 1'b1, 8);
        set_in(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            obs = {u_if.out1, u_if.out1_x, u_if.w4_conflict, u_if.w4_float};
            exp = {(k >= 6) ? 1'b1 : 1'b0, 3'b000};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rise k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_fall();
        logic [3:0] obs, exp;
        start_from_reset(1'b1, 1'b1, 10);
        set_in(1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            obs = {u_if.out1, u_if.out1_x, u_if.w4_conflict, u_if.w4_float};
            exp = {(k < 6) ? 1'b1 : 1'b0, 3'b000};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL fall k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] obs, exp;
        logic       xk;
        start_from_reset(1'b1, 1'b0, 10);
        set_in(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            xk  = (k == 4 || k == 5) ? 1'b1 : 1'b0;
            obs = {xk ? 1'b0 : u_if.out1, u_if.out1_x, u_if.w4_conflict, u_if.w4_float};
            exp = {(!xk && k >= 6) ? 1'b1 : 1'b0, xk,
                   (k == 2 || k == 3) ? 1'b1 : 1'b0, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL contention k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_float();
        logic [3:0] obs, exp;
        start_from_reset(1'b1, 1'b1, 10);
        set_in(1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            obs = {u_if.out1, u_if.out1_x, u_if.w4_conflict, u_if.w4_float};
            exp = {(k < 6) ? 1'b1 : 1'b0, 2'b00, (k == 2 || k == 3) ? 1'b1 : 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL float k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_midreset();
        logic [3:0] obs, exp;
        start_from_reset(1'b1, 1'b1, 10);
        set_in(1'b0, 1'b0); cyc(); cyc();
        rst = 1'b1; set_in(1'b1, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            cyc();
            rst = 1'b0;
            obs = {u_if.out1, u_if.out1_x, u_if.w4_conflict, u_if.w4_float};
            exp = {(k >= 6) ? 1'b1 : 1'b0, 3'b000};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midreset k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_toggle();
        logic [3:0] obs, exp;
        start_from_reset(1'b0, 1'b0, 0);
        for (int i = 0; i < 64; i++) begin
            set_in(((i / 2) % 2) == 1, ((i / 4) % 2) == 1);
            cyc();
            obs = {e_x ? 1'b0 : u_if.out1, u_if.out1_x, u_if.w4_conflict, u_if.w4_float};
            exp = {e_x ? 1'b0 : e_out1, e_x, e_conf, e_float};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL toggle i=%0d got=%b want=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] obs, exp;
        start_from_reset(1'b0, 1'b0, 0);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) begin
                set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end
            cyc();
            obs = {e_x ? 1'b0 : u_if.out1, u_if.out1_x, u_if.w4_conflict, u_if.w4_float};
            exp = {e_x ? 1'b0 : e_out1, e_x, e_conf, e_float};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL random i=%0d rst=%0b got=%b want=%b", i, rst, obs, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        set_in(1'b0, 1'b0);
        test_reset();
        test_rise();
        test_fall();
        test_contention();
        test_float();
        test_midreset();
        test_toggle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
